// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared types for the snooping-bus controller: bus operation encoding and
// arbiter FSM states.
package snoop_bus_pkg;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NON  = 2'b11
  } bus_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SNOOP,
    ST_MEM,
    ST_WB,
    ST_DONE
  } arb_state_t;

  // Value driven on a core's snoop slice when it has nothing to snoop.
  localparam bus_op_t BUS_IDLE_OP = BUS_NON;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Bundle of L1-facing and memory-facing signals of the snooping bus.
// master = arbiter side, slave = cores/memory side.
interface snoop_bus_arbiter_if #(
  parameter int unsigned NUM_CORES = 2
);
  import snoop_bus_pkg::*;

  logic [NUM_CORES-1:0]        core_req_i;
  logic [2*NUM_CORES-1:0]      core_op_i;
  logic [BUS_AW*NUM_CORES-1:0] core_addr_i;
  logic [NUM_CORES-1:0]        core_hit_i;
  logic [NUM_CORES-1:0]        core_flush_i;
  logic [BUS_DW*NUM_CORES-1:0] core_data_i;
  logic [NUM_CORES-1:0]        grant_o;
  logic [2*NUM_CORES-1:0]      snoop_op_o;
  logic [BUS_AW-1:0]           bus_addr_o;
  logic [BUS_DW-1:0]           bus_data_o;
  logic                        shared_o;
  logic [NUM_CORES-1:0]        done_o;
  logic                        mem_rd_o;
  logic                        mem_wr_o;
  logic [BUS_AW-1:0]           mem_addr_o;
  logic [BUS_DW-1:0]           mem_wdata_o;
  logic [BUS_DW-1:0]           mem_rdata_i;
  logic                        mem_ack_i;

  modport master (
    input  core_req_i, core_op_i, core_addr_i, core_hit_i, core_flush_i,
           core_data_i, mem_rdata_i, mem_ack_i,
    output grant_o, snoop_op_o, bus_addr_o, bus_data_o, shared_o, done_o,
           mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output core_req_i, core_op_i, core_addr_i, core_hit_i, core_flush_i,
           core_data_i, mem_rdata_i, mem_ack_i,
    input  grant_o, snoop_op_o, bus_addr_o, bus_data_o, shared_o, done_o,
           mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/snoop_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_winner+1 with
// wrap; the caller owns the pointer register.
module rr_arbiter #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     last_winner,
  output logic [NUM_CORES-1:0] winner,
  output logic                 valid
);

  logic [31:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    // off == NUM_CORES lands back on last_winner, so it is considered last.
    for (int unsigned off = 1; off <= NUM_CORES; off++) begin
      idx = (32'(last_winner) + off) % NUM_CORES;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus controller: round-robin grant, snoop broadcast, then
// cache-to-cache supply, write-back or memory read.
module snoop_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int unsigned NUM_CORES = 2
) (
  input logic                 clk,
  input logic                 reset,
  snoop_bus_arbiter_if.master bus
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  arb_state_t state_q, state_d;

  logic [NUM_CORES-1:0] arb_oh, win_oh_q, hits, done_q;
  logic                 arb_valid;
  logic [IDX_W-1:0]     arb_idx, win_idx_q, last_q;
  bus_op_t              op_q, win_op;
  logic [BUS_AW-1:0]    addr_q, win_addr;
  logic [BUS_DW-1:0]    data_q, wdata_q, sup_data;
  logic                 sup_flush, sup_found, shared_q;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_arbiter (
    .req         (bus.core_req_i),
    .last_winner (last_q),
    .winner      (arb_oh),
    .valid       (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (arb_oh[i]) arb_idx = IDX_W'(i);
    end
  end

  // Winner's request fields, selected live so GRANT can branch on the op.
  always_comb begin
    win_op   = BUS_IDLE_OP;
    win_addr = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (win_oh_q[i]) begin
        win_op   = bus_op_t'(bus.core_op_i[2*i +: 2]);
        win_addr = bus.core_addr_i[BUS_AW*i +: BUS_AW];
      end
    end
  end

  // Supplier is the lowest-index non-winner reporting a snoop hit.
  always_comb begin
    hits      = bus.core_hit_i & ~win_oh_q;
    sup_data  = '0;
    sup_flush = 1'b0;
    sup_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (hits[i] && !sup_found) begin
        sup_found = 1'b1;
        sup_data  = bus.core_data_i[BUS_DW*i +: BUS_DW];
        sup_flush = bus.core_flush_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arb_valid) state_d = ST_GRANT;
      ST_GRANT: state_d = (win_op == BUS_NON) ? ST_DONE : ST_SNOOP;
      ST_SNOOP: begin
        if (op_q == BUS_UPGR)  state_d = ST_DONE;
        else if (sup_found)    state_d = sup_flush ? ST_WB : ST_DONE;
        else                   state_d = ST_MEM;
      end
      ST_MEM:   if (bus.mem_ack_i) state_d = ST_DONE;
      ST_WB:    if (bus.mem_ack_i) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.grant_o    = (state_q != ST_IDLE) ? win_oh_q : '0;
    bus.mem_rd_o   = (state_q == ST_MEM);
    bus.mem_wr_o   = (state_q == ST_WB);
    bus.snoop_op_o = '1;
    if (state_q == ST_SNOOP) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (!win_oh_q[i]) bus.snoop_op_o[2*i +: 2] = op_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_oh_q  <= '0;
      win_idx_q <= '0;
      last_q    <= IDX_W'(NUM_CORES - 1);
      op_q      <= BUS_IDLE_OP;
      addr_q    <= '0;
      data_q    <= '0;
      wdata_q   <= '0;
      shared_q  <= 1'b0;
      done_q    <= '0;
    end else begin
      done_q <= (state_d == ST_DONE) ? win_oh_q : '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            win_oh_q  <= arb_oh;
            win_idx_q <= arb_idx;
          end
        end
        ST_GRANT: begin
          op_q   <= win_op;
          addr_q <= win_addr;
        end
        ST_SNOOP: begin
          shared_q <= |hits;
          if (op_q != BUS_UPGR && sup_found) begin
            data_q <= sup_data;
            if (sup_flush) wdata_q <= sup_data;
          end
        end
        ST_MEM: begin
          if (bus.mem_ack_i) data_q <= bus.mem_rdata_i;
        end
        ST_DONE: begin
          last_q   <= win_idx_q;
          shared_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_addr_o  = addr_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.bus_data_o  = data_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.shared_o    = shared_q;
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter with two cores; expectations are
// hand-computed constants checked by immediate assertions.
module tb_snoop_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  snoop_bus_arbiter_if #(.NUM_CORES(2)) bus ();

  snoop_bus_arbiter #(.NUM_CORES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int c, input logic req, input logic [1:0] op,
                          input logic [31:0] addr);
    bus.core_req_i[c]          = req;
    bus.core_op_i[2*c +: 2]    = op;
    bus.core_addr_i[32*c +: 32] = addr;
  endtask

  task automatic set_snoop(input int c, input logic hit, input logic flush,
                           input logic [31:0] data);
    bus.core_hit_i[c]           = hit;
    bus.core_flush_i[c]         = flush;
    bus.core_data_i[32*c +: 32] = data;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_grant"},  32'(bus.grant_o),    32'h0);
    chk({pfx, "_done"},   32'(bus.done_o),     32'h0);
    chk({pfx, "_shared"}, 32'(bus.shared_o),   32'h0);
    chk({pfx, "_mem_rd"}, 32'(bus.mem_rd_o),   32'h0);
    chk({pfx, "_mem_wr"}, 32'(bus.mem_wr_o),   32'h0);
    chk({pfx, "_snoop"},  32'(bus.snoop_op_o), 32'hF);
    chk({pfx, "_addr"},   bus.bus_addr_o,      32'h0);
    chk({pfx, "_data"},   bus.bus_data_o,      32'h0);
    chk({pfx, "_wdata"},  bus.mem_wdata_o,     32'h0);
  endtask

  initial begin
    bus.core_req_i   = '0;
    bus.core_op_i    = '1;
    bus.core_addr_i  = '0;
    bus.core_hit_i   = '0;
    bus.core_flush_i = '0;
    bus.core_data_i  = '0;
    bus.mem_rdata_i  = '0;
    bus.mem_ack_i    = 1'b0;

    tick(); tick();
    reset = 1'b0;
    chk_reset_outputs("rst");

    // Basic miss: core 0 BusRd, memory acks on the second MEM cycle.
    set_core(0, 1'b1, 2'b00, 32'h0000_0104);
    tick();
    chk("miss_grant", 32'(bus.grant_o), 32'h1);
    set_core(0, 1'b0, 2'b00, 32'h0000_0104);
    tick();
    chk("miss_snoop", 32'(bus.snoop_op_o), 32'h3);
    chk("miss_addr", bus.bus_addr_o, 32'h0000_0104);
    tick();
    chk("miss_rd1", 32'(bus.mem_rd_o), 32'h1);
    chk("miss_maddr", bus.mem_addr_o, 32'h0000_0104);
    tick();
    chk("miss_rd2", 32'(bus.mem_rd_o), 32'h1);
    chk("miss_nodone", 32'(bus.done_o), 32'h0);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack_i = 1'b0;
    chk("miss_done", 32'(bus.done_o), 32'h1);
    chk("miss_data", bus.bus_data_o, 32'hDEAD_BEEF);
    chk("miss_shared", 32'(bus.shared_o), 32'h0);
    chk("miss_rd_off", 32'(bus.mem_rd_o), 32'h0);
    tick();
    chk("miss_done_once", 32'(bus.done_o), 32'h0);
    chk("miss_grant_off", 32'(bus.grant_o), 32'h0);
    chk("miss_data_hold", bus.bus_data_o, 32'hDEAD_BEEF);

    // Upgrade: core 0 BusUpgr; core 1 hit sets shared but supplies nothing.
    set_core(0, 1'b1, 2'b01, 32'h0000_0300);
    set_snoop(1, 1'b1, 1'b0, 32'h0000_AAAA);
    tick();
    chk("upg_grant", 32'(bus.grant_o), 32'h1);
    set_core(0, 1'b0, 2'b01, 32'h0000_0300);
    tick();
    chk("upg_snoop", 32'(bus.snoop_op_o), 32'h7);
    chk("upg_early", 32'(bus.done_o), 32'h0);
    tick();
    chk("upg_done", 32'(bus.done_o), 32'h1);
    chk("upg_rd", 32'(bus.mem_rd_o), 32'h0);
    chk("upg_wr", 32'(bus.mem_wr_o), 32'h0);
    chk("upg_data", bus.bus_data_o, 32'hDEAD_BEEF);
    chk("upg_shared", 32'(bus.shared_o), 32'h1);
    chk("upg_snoop_off", 32'(bus.snoop_op_o), 32'hF);
    set_snoop(1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("upg_shared_clr", 32'(bus.shared_o), 32'h0);

    // Cache-to-cache with flush: core 1 BusRd, core 0 hits and flushes.
    set_core(1, 1'b1, 2'b00, 32'h0000_0200);
    set_snoop(0, 1'b1, 1'b1, 32'h1234_5678);
    tick();
    chk("c2c_grant", 32'(bus.grant_o), 32'h2);
    set_core(1, 1'b0, 2'b00, 32'h0000_0200);
    tick();
    chk("c2c_snoop", 32'(bus.snoop_op_o), 32'hC);
    tick();
    chk("c2c_wr", 32'(bus.mem_wr_o), 32'h1);
    chk("c2c_rd", 32'(bus.mem_rd_o), 32'h0);
    chk("c2c_wdata", bus.mem_wdata_o, 32'h1234_5678);
    chk("c2c_data", bus.bus_data_o, 32'h1234_5678);
    chk("c2c_shared", 32'(bus.shared_o), 32'h1);
    chk("c2c_maddr", bus.mem_addr_o, 32'h0000_0200);
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    set_snoop(0, 1'b0, 1'b0, 32'h0);
    chk("c2c_done", 32'(bus.done_o), 32'h2);
    chk("c2c_wr_off", 32'(bus.mem_wr_o), 32'h0);
    tick();
    chk("c2c_idle_shared", 32'(bus.shared_o), 32'h0);

    // Fairness: both cores request BusNoN continuously; grants alternate.
    set_core(0, 1'b1, 2'b11, 32'h0);
    set_core(1, 1'b1, 2'b11, 32'h0);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("fair_grant", 32'(bus.grant_o), (t % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk("fair_done", 32'(bus.done_o), (t % 2 == 0) ? 32'h1 : 32'h2);
      if (t == 3) begin
        set_core(0, 1'b0, 2'b11, 32'h0);
        set_core(1, 1'b0, 2'b11, 32'h0);
      end
      tick();
      chk("fair_idle", 32'(bus.grant_o), 32'h0);
    end

    // Dropped request: core 0 BusRdX drops req in SNOOP, core 1 supplies.
    set_core(0, 1'b1, 2'b10, 32'h0000_0500);
    set_snoop(1, 1'b1, 1'b0, 32'hCAFE_F00D);
    tick();
    chk("drop_grant", 32'(bus.grant_o), 32'h1);
    tick();
    set_core(0, 1'b0, 2'b10, 32'h0000_0500);
    chk("drop_snoop", 32'(bus.snoop_op_o), 32'hB);
    tick();
    chk("drop_done", 32'(bus.done_o), 32'h1);
    chk("drop_data", bus.bus_data_o, 32'hCAFE_F00D);
    chk("drop_shared", 32'(bus.shared_o), 32'h1);
    set_snoop(1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("drop_idle", 32'(bus.done_o), 32'h0);

    // Reset in MEM: core 1 miss aborted; pointer returns to core-0 priority.
    set_core(1, 1'b1, 2'b00, 32'h0000_0600);
    tick();
    chk("rmem_grant", 32'(bus.grant_o), 32'h2);
    set_core(1, 1'b0, 2'b00, 32'h0000_0600);
    tick();
    tick();
    chk("rmem_rd", 32'(bus.mem_rd_o), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outputs("rmem");
    set_core(0, 1'b1, 2'b11, 32'h0);
    set_core(1, 1'b1, 2'b11, 32'h0);
    tick();
    chk("rmem_first", 32'(bus.grant_o), 32'h1);
    chk("rmem_nodone", 32'(bus.done_o), 32'h0);
    set_core(0, 1'b0, 2'b11, 32'h0);
    set_core(1, 1'b0, 2'b11, 32'h0);
    tick();
    chk("rmem_done", 32'(bus.done_o), 32'h1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Shared snooping-bus controller for the multicore MESI cache system. Arbitrates bus requests from the per-core L1 caches round-robin and grants one core at a time. Broadcasts the winner's bus operation to every other L1 for snooping, then sequences the data phase: cache-to-cache supply, write-back of flushed lines, or a read from main memory. Sits between the L1 cache subsystems and the data memory port.

## Interface
- NUM_CORES, 2: number of L1 requesters; must be at least 2.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- core_req_i  in  NUM_CORES  per-core `req_core` from the L1 caches.
- core_op_i  in  2*NUM_CORES  per-core bus operation; slice i is [2i+1:2i].
- core_addr_i  in  32*NUM_CORES  per-core bus address.
- core_hit_i  in  NUM_CORES  per-core snoop hit (`cache_hit_out`).
- core_flush_i  in  NUM_CORES  per-core snoop flush (`flush_out`).
- core_data_i  in  32*NUM_CORES  per-core snoop data (`bus_data_out`).
- grant_o  out  NUM_CORES  one-hot grant.
- snoop_op_o  out  2*NUM_CORES  operation broadcast to each core; 2'b11 when not snooping.
- bus_addr_o  out  32  latched transaction address, broadcast to all cores.
- bus_data_o  out  32  response data to the requester.
- shared_o  out  1  OR of snoop hits from non-winners; this is the requester's `cache_hit_in`.
- done_o  out  NUM_CORES  one-cycle completion pulse to the winner.
- mem_rd_o  out  1  memory read request.
- mem_wr_o  out  1  memory write-back request.
- mem_addr_o  out  32  memory address; equals bus_addr_o.
- mem_wdata_o  out  32  write-back data.
- mem_rdata_i  in  32  memory read data.
- mem_ack_i  in  1  memory completion; sampled only in MEM and WB.

## Operation

**Operation encoding:** BusRd=00, BusUpgr=01, BusRdX=10, BusNoN=11.

**FSM states:** IDLE, GRANT, SNOOP, MEM, WB, DONE.

- **IDLE**
  - If any core_req_i is set, select the winner round-robin, searching upward from last_winner+1 with wrap.
  - Register the winner. Next state is GRANT.
  - No request: stay in IDLE.
- **GRANT**
  - grant_o[winner]=1.
  - Latch the winner's core_op_i and core_addr_i into op_q and addr_q.
  - If op_q==BusNoN, go to DONE; otherwise go to SNOOP.
- **SNOOP** (one cycle)
  - snoop_op_o carries op_q on every non-winner slice; the winner's slice is 2'b11.
  - Form hits = core_hit_i & ~winner_onehot.
  - shared_o <= |hits, held until IDLE.
  - BusUpgr: go to DONE.
  - Any hit: the supplier is the lowest-index hitting core. bus_data_o <= its core_data_i.
    - If that core also flushes: mem_wdata_o <= the same data, then go to WB.
    - Otherwise go to DONE.
  - No hit: go to MEM.
- **MEM:** mem_rd_o=1 until mem_ack_i. On ack, bus_data_o <= mem_rdata_i, then go to DONE.
- **WB:** mem_wr_o=1 until mem_ack_i, then go to DONE.
- **DONE**
  - done_o[winner]=1 and grant still held.
  - last_winner <= winner. Next state is IDLE.
- **Leaving DONE:** grant_o, shared_o and done_o clear on entry to IDLE. bus_data_o holds its value until the next transaction writes it.
- **Requester behaviour mid-transaction:** if the winner drops core_req_i after GRANT, the transaction still runs to DONE. Requests are only re-evaluated in IDLE.

## Timing
- **Reset values:**
  - state=IDLE and last_winner=NUM_CORES-1, so core 0 has first priority.
  - grant_o, done_o, shared_o, mem_rd_o, mem_wr_o are 0.
  - snoop_op_o is all 2'b11.
  - bus_addr_o, bus_data_o, mem_wdata_o are 0.
- **Reset mid-transaction:** the transaction is aborted. mem_rd_o and mem_wr_o drop the next cycle. No done_o is issued.
- **Latencies** (request sampled in IDLE at cycle 0):
  - grant_o is asserted at cycle 1.
  - BusNoN: done at cycle 2.
  - BusUpgr, or cache supply without flush: done at cycle 3.
  - MEM or WB with single-cycle ack: done at cycle 4. Each extra wait cycle adds one.
- **Registered outputs:** all outputs are registered, except snoop_op_o, grant_o, mem_rd_o and mem_wr_o, which are decoded from state and the winner.
- **Memory handshake:** mem_rd_o and mem_wr_o are never asserted together.
- **Back-to-back requests:** a core requesting continuously while others also request waits at most NUM_CORES-1 transactions.
- **Simultaneous requests:** resolved purely by the round-robin pointer.

## Structure
- **Package snoop_bus_pkg:**
  - bus_op_t enum (BUS_RD, BUS_UPGR, BUS_RDX, BUS_NON).
  - arb_state_t enum.
  - constant BUS_IDLE_OP = BUS_NON.
- **Sub-module rr_arbiter:** parameterised by NUM_CORES. Inputs are req and last_winner; outputs are a one-hot winner and a valid flag. It is purely combinational; the FSM owns the pointer register.

## Test plan
- **Basic miss to memory:** core 0 issues BusRd, addr 0x0000_0104, no snoop hits, mem acks after 2 cycles with 0xDEAD_BEEF. Required: mem_rd_o is held for those cycles; bus_data_o=0xDEAD_BEEF; shared_o=0; done_o[0] pulses exactly once.
- **Cache-to-cache with flush:** core 1 issues BusRd while core 0 asserts hit and flush with data 0x1234_5678. Required: bus_data_o=0x1234_5678; shared_o=1; mem_wr_o asserted with mem_wdata_o=0x1234_5678; no mem_rd_o.
- **Upgrade:** core 0 issues BusUpgr. Required: snoop_op_o shows 01 on core 1's slice and 11 on core 0's slice for one cycle; done_o[0] at cycle 3; no memory activity.
- **Fairness:** both cores request continuously with BusNoN. Required: grants alternate 0,1,0,1 and each transaction completes in 3 cycles.
- **Reset in MEM:** assert reset while mem_rd_o=1. Required: all outputs return to their reset values the next cycle, no done_o is issued, and the next request from core 0 is granted first.
- **Dropped request:** the winner deasserts core_req_i during SNOOP. Required: the transaction completes and done_o still pulses.
